idma_channel_arbiter: RTL and testbench
=======================================

IDMA_CHANNEL_ARBITER -- requirements
Module: idma_channel_arbiter

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of requesting frontends (2..16).
REQ-002 SHALL have parameter MaxOutstanding, default 8, completion-tracking depth (1..32).
REQ-003 SHALL have parameter burst_req_t, default logic, DMA burst request type.
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port burst_req_i, input, NumChannels x burst_req_t, per-channel burst request.
REQ-007 SHALL have port valid_i, input, NumChannels, per-channel request valid.
REQ-008 SHALL have port ready_o, output, NumChannels, per-channel request accept.
REQ-009 SHALL have port burst_req_o, output, burst_req_t, request forwarded to the backend.
REQ-010 SHALL have port valid_o, output, 1, backend request valid.
REQ-011 SHALL have port ready_i, input, 1, backend request accept.
REQ-012 SHALL have port trans_complete_i, input, 1, backend in-order completion pulse.
REQ-013 SHALL have port trans_complete_o, output, NumChannels, per-channel completion pulse.
REQ-014 SHALL have port outstanding_o, output, $clog2(MaxOutstanding+1), issued-but-incomplete count.
REQ-015 SHALL have port idle_o, output, 1, high when outstanding_o == 0.
REQ-016 SHALL have port err_o, output, 1, one-cycle pulse on completion with no outstanding transfer.

Function
REQ-017 SHALL hold state: round-robin pointer rr_ptr, lock flag with locked index, and a FIFO of channel indices of depth MaxOutstanding.
REQ-018 SHALL, when unlocked, grant the first channel with valid_i set, searching cyclically from rr_ptr upward.
REQ-019 SHALL drive burst_req_o = burst_req_i[grant], valid_o = valid_i[grant] & ~fifo_full, ready_o[grant] = ready_i & ~fifo_full, all other ready_o bits 0; burst_req_o = '0 when no grant.
REQ-020 SHALL enter LOCKED on the granted index when valid_o=1 and ready_i=0, keeping the grant fixed so burst_req_o stays stable until handshake.
REQ-021 SHALL release the lock without handshake if the locked channel deasserts valid_i; re-arbitration occurs in the next cycle.
REQ-022 SHALL, on handshake (valid_o & ready_i), push the grant index into the FIFO, set rr_ptr = (grant+1) mod NumChannels, and clear the lock.
REQ-023 SHALL, when the FIFO is full, hold valid_o=0 and all ready_o=0; a pop in the same cycle does not enable a push in that cycle.
REQ-024 SHALL, on trans_complete_i with FIFO non-empty, pulse trans_complete_o[head] combinationally in that cycle and pop the head.
REQ-025 SHALL, on trans_complete_i with FIFO empty, pulse err_o for that cycle, leave state unchanged, and assert no trans_complete_o bit.
REQ-026 SHALL treat simultaneous push and pop on a non-empty FIFO as count-neutral; on an empty FIFO the pop is the REQ-025 error and only the push takes effect.
REQ-027 SHALL at most one trans_complete_o bit high per cycle; outstanding_o equals FIFO occupancy and never exceeds MaxOutstanding.
REQ-028 SHALL not wrap pointers incorrectly: FIFO read/write pointers wrap modulo MaxOutstanding, also for non-power-of-two depths.

Reset
REQ-029 SHALL, with rst_ni=0 at a clock edge, clear FIFO, set rr_ptr=0, clear lock; outputs then: valid_o=0 unless a valid_i is high (combinational), trans_complete_o=0, err_o=0, outstanding_o=0, idle_o=1.
REQ-030 SHALL discard all outstanding entries on reset mid-operation; completions after reset produce err_o.

Verification
REQ-031 SHALL cover: valid_i=4'b1111, ready_i=1 for 4 cycles -> grants 0,1,2,3 in order; outstanding_o 1..4.
REQ-032 SHALL cover: ch2 valid, ready_i=0 for 3 cycles, ch0 raises valid in cycle 2 -> burst_req_o stays ch2's, grant stays 2 until ready_i=1; next grant ch0.
REQ-033 SHALL cover: MaxOutstanding=2, three handshakes attempted, no completions -> third blocked, valid_o=0, ready_o=0, outstanding_o=2; one trans_complete_i -> third accepted next cycle.
REQ-034 SHALL cover: issue ch1 then ch3, two trans_complete_i pulses -> trans_complete_o=4'b0010 then 4'b1000; idle_o=1 afterwards.
REQ-035 SHALL cover: trans_complete_i with idle_o=1 -> err_o=1 one cycle, trans_complete_o=0, outstanding_o=0.
REQ-036 SHALL cover: rst_ni=0 with outstanding_o=3 -> after edge outstanding_o=0, idle_o=1, next grant starts from channel 0.

Source files
------------

// File: rtl/idma_channel_arbiter.sv
// idma_channel_arbiter
//   Round-robin arbiter that funnels NumChannels DMA frontends into one
//   backend. A granted request is locked until it handshakes, so the
//   forwarded burst stays stable. Each accepted request's channel index goes
//   into an in-order FIFO. That FIFO routes the backend's completion pulses
//   back to the channel that issued the request.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   burst_req_i/valid_i      per-channel requests
//   ready_o                  per-channel accept (only the granted lane)
//   burst_req_o/valid_o      request forwarded to the backend
//   ready_i                  backend accept
//   trans_complete_i         backend in-order completion pulse
//   trans_complete_o         per-channel completion pulse
//   outstanding_o, idle_o    issued-but-incomplete count, count == 0
//   err_o                    completion arrived with nothing outstanding

// Per-channel output lane: decodes grant/head into this channel's strobes.
module idma_arb_lane #(
  parameter int unsigned CW  = 2,
  parameter int unsigned Idx = 0
) (
  input  logic [CW-1:0] i_grant,
  input  logic          i_ready_en,
  input  logic [CW-1:0] i_head,
  input  logic          i_pop,
  output logic          o_ready,
  output logic          o_done
);
  assign o_ready = i_ready_en & (i_grant == CW'(Idx));
  assign o_done  = i_pop      & (i_head  == CW'(Idx));
endmodule

module idma_channel_arbiter #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         burst_req_t    = logic,
  localparam int unsigned OW = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  burst_req_t [NumChannels-1:0] burst_req_i,
  input  logic       [NumChannels-1:0] valid_i,
  output logic       [NumChannels-1:0] ready_o,
  output burst_req_t                   burst_req_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  input  logic                         trans_complete_i,
  output logic       [NumChannels-1:0] trans_complete_o,
  output logic       [OW-1:0]          outstanding_o,
  output logic                         idle_o,
  output logic                         err_o
);
  localparam int unsigned CW = (NumChannels    > 1) ? $clog2(NumChannels)    : 1;
  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // arbitration state
  logic [CW-1:0] r_rr_ptr;
  logic          r_locked;
  logic [CW-1:0] r_lock_idx;

  // completion-order FIFO of channel indices
  logic [CW-1:0] r_fifo [MaxOutstanding];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [OW-1:0] r_count;

  logic [CW-1:0] w_grant;
  logic          w_has_grant;
  logic [CW:0]   w_cand;
  logic          w_full, w_empty;
  logic          w_hs, w_push, w_pop;
  logic          w_ready_en;
  logic [CW-1:0] w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // explicit wrap so non-power-of-two depths work
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
  endfunction

  // Grant: a locked index wins outright; otherwise the first valid channel
  // at or after r_rr_ptr. The loop runs downward so the smallest offset is
  // the last assignment and therefore wins.
  always_comb begin
    w_grant     = '0;
    w_has_grant = 1'b0;
    w_cand      = '0;
    if (r_locked) begin
      w_grant     = r_lock_idx;
      w_has_grant = 1'b1;
    end else begin
      for (int i = NumChannels - 1; i >= 0; i--) begin
        w_cand = {1'b0, r_rr_ptr} + (CW+1)'(i);
        if (w_cand >= (CW+1)'(NumChannels))
          w_cand = w_cand - (CW+1)'(NumChannels);
        if (valid_i[w_cand[CW-1:0]]) begin
          w_grant     = w_cand[CW-1:0];
          w_has_grant = 1'b1;
        end
      end
    end
  end

  assign w_full     = (r_count == OW'(MaxOutstanding));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_fifo[r_rd_ptr];

  assign valid_o     = w_has_grant & valid_i[w_grant] & ~w_full;
  assign burst_req_o = w_has_grant ? burst_req_i[w_grant] : '0;
  assign w_ready_en  = w_has_grant & ready_i & ~w_full;

  assign w_hs   = valid_o & ready_i;
  assign w_push = w_hs;
  // A completion with nothing outstanding is an error, not a pop.
  assign w_pop  = trans_complete_i & ~w_empty;
  assign err_o  = trans_complete_i &  w_empty;

  assign outstanding_o = r_count;
  assign idle_o        = w_empty;

  for (genvar g = 0; g < NumChannels; g++) begin : g_lane
    idma_arb_lane #(
      .CW  (CW),
      .Idx (g)
    ) u_lane (
      .i_grant    (w_grant),
      .i_ready_en (w_ready_en),
      .i_head     (w_head),
      .i_pop      (w_pop),
      .o_ready    (ready_o[g]),
      .o_done     (trans_complete_o[g])
    );
  end

  // FIFO storage needs no reset: the pointers/count define what is live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_grant;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr   <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      // push never happens while full, pop never while empty
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OW'(1);
        2'b01:   r_count <= r_count - OW'(1);
        default: r_count <= r_count;
      endcase

      if (w_hs) begin
        r_locked <= 1'b0;
        r_rr_ptr <= (w_grant == CW'(NumChannels - 1)) ? '0 : w_grant + CW'(1);
      end else if (r_locked && !valid_i[r_lock_idx]) begin
        // frontend withdrew; arbitrate afresh next cycle
        r_locked <= 1'b0;
      end else if (valid_o && !ready_i) begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_grant;
      end
    end
  end

endmodule

// File: tb/tb_idma_channel_arbiter.sv
module tb_idma_channel_arbiter;
  localparam int N  = 4;
  localparam int MO = 5;
  localparam int OW = $clog2(MO + 1);
  typedef logic [7:0] req_t;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  req_t      [N-1:0]     burst_req_i;
  logic      [N-1:0]     valid_i, ready_o, trans_complete_o;
  req_t                  burst_req_o;
  logic                  valid_o, ready_i, trans_complete_i, idle_o, err_o;
  logic      [OW-1:0]    outstanding_o;

  always #5 clk = ~clk;

  idma_channel_arbiter #(
    .NumChannels    (N),
    .MaxOutstanding (MO),
    .burst_req_t    (req_t)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .burst_req_i      (burst_req_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .burst_req_o      (burst_req_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .trans_complete_i (trans_complete_i),
    .trans_complete_o (trans_complete_o),
    .outstanding_o    (outstanding_o),
    .idle_o           (idle_o),
    .err_o            (err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: rr pointer, lock, and a queue of issued channel ids
  int m_rr;
  bit m_locked;
  int m_lidx;
  int m_q[$];

  // DUT outputs sampled in the last step, for directed checks
  logic         s_vo, s_err, s_idle;
  logic [N-1:0] s_rdy, s_tco;
  req_t         s_bo;
  int           s_out;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, model advances
  // at the rising edge.
  task automatic step(input logic [N-1:0] v, input logic rdy, input logic tc, input logic rst);
    int gnt;
    bit has, full, pop, hs;
    logic         e_vo;
    logic [N-1:0] e_rdy, e_tco;
    req_t         e_bo;
    @(negedge clk);
    valid_i          = v;
    ready_i          = rdy;
    trans_complete_i = tc;
    rst_ni           = ~rst;
    #1;
    full = (m_q.size() == MO);
    has  = 0;
    gnt  = 0;
    if (m_locked) begin
      has = 1;
      gnt = m_lidx;
    end else begin
      for (int k = 0; k < N; k++)
        if (!has && v[(m_rr + k) % N]) begin
          has = 1;
          gnt = (m_rr + k) % N;
        end
    end
    e_vo  = has && v[gnt] && !full;
    e_rdy = (has && rdy && !full) ? (N'(1) << gnt) : '0;
    e_bo  = has ? burst_req_i[gnt] : '0;
    pop   = tc && (m_q.size() > 0);
    e_tco = pop ? (N'(1) << m_q[0]) : '0;

    s_vo   = valid_o;
    s_rdy  = ready_o;
    s_bo   = burst_req_o;
    s_tco  = trans_complete_o;
    s_err  = err_o;
    s_idle = idle_o;
    s_out  = int'(outstanding_o);

    chk("valid_o", 32'(s_vo), 32'(e_vo));
    chk("ready_o", 32'(s_rdy), 32'(e_rdy));
    chk("burst_req_o", 32'(s_bo), 32'(e_bo));
    chk("trans_complete_o", 32'(s_tco), 32'(e_tco));
    chk("err_o", 32'(s_err), 32'(tc && m_q.size() == 0));
    chk("outstanding_o", 32'(s_out), 32'(m_q.size()));
    chk("idle_o", 32'(s_idle), 32'(m_q.size() == 0));

    hs = e_vo && rdy;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_rr     = 0;
      m_locked = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (hs)  m_q.push_back(gnt);
      if (hs) begin
        m_locked = 0;
        m_rr     = (gnt + 1) % N;
      end else if (m_locked && !v[m_lidx]) begin
        m_locked = 0;
      end else if (e_vo && !rdy) begin
        m_locked = 1;
        m_lidx   = gnt;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < MO + 1 && m_q.size() > 0; i++) step('0, 0, 1, 0);
  endtask

  initial begin
    rst_ni = 0; valid_i = '0; ready_i = 0; trans_complete_i = 0;
    for (int c = 0; c < N; c++) burst_req_i[c] = 8'hA0 + 8'(c);
    m_q.delete(); m_rr = 0; m_locked = 0; m_lidx = 0;
    repeat (2) @(posedge clk);

    // reset state
    step('0, 0, 0, 1);
    chk("rst_idle", 32'(s_idle), 1);
    chk("rst_out", 32'(s_out), 0);

    // all channels requesting, backend always ready: 0,1,2,3 in order
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 1, 0, 0);
      chk("rr_ready", 32'(s_rdy), 32'(1 << k));
      chk("rr_out", 32'(s_out), 32'(k));
    end
    step('0, 0, 1, 0);
    chk("rr_out4", 32'(s_out), 4);
    chk("rr_head", 32'(s_tco), 32'h1);
    drain();

    // lock holds ch2 while ch0 shows up; ch0 next after the handshake
    step(4'b0100, 0, 0, 0);
    chk("lock_bo0", 32'(s_bo), 32'hA2);
    step(4'b0101, 0, 0, 0);
    chk("lock_bo1", 32'(s_bo), 32'hA2);
    step(4'b0101, 0, 0, 0);
    chk("lock_bo2", 32'(s_bo), 32'hA2);
    step(4'b0101, 1, 0, 0);
    chk("lock_hs", 32'(s_rdy), 32'b0100);
    step(4'b0101, 1, 0, 0);
    chk("lock_next", 32'(s_rdy), 32'b0001);
    drain();

    // completions routed in issue order
    step(4'b0010, 1, 0, 0);
    step(4'b1000, 1, 0, 0);
    step('0, 0, 1, 0);
    chk("cpl_first", 32'(s_tco), 32'b0010);
    step('0, 0, 1, 0);
    chk("cpl_second", 32'(s_tco), 32'b1000);
    step('0, 0, 0, 0);
    chk("cpl_idle", 32'(s_idle), 1);

    // completion with nothing outstanding
    step('0, 0, 1, 0);
    chk("err_pulse", 32'(s_err), 1);
    chk("err_tco", 32'(s_tco), 0);
    chk("err_out", 32'(s_out), 0);

    // fill to MaxOutstanding; a pop does not free a push in the same cycle
    for (int k = 0; k < MO; k++) step(4'b1111, 1, 0, 0);
    step(4'b1111, 1, 0, 0);
    chk("full_vo", 32'(s_vo), 0);
    chk("full_rdy", 32'(s_rdy), 0);
    chk("full_out", 32'(s_out), MO);
    step(4'b1111, 1, 1, 0);
    chk("full_pop_vo", 32'(s_vo), 0);
    step(4'b1111, 1, 0, 0);
    chk("full_after_vo", 32'(s_vo), 1);
    chk("full_after_out", 32'(s_out), MO - 1);
    drain();

    // reset mid-operation discards entries; arbitration restarts at ch0
    for (int k = 0; k < 3; k++) step(4'b1111, 1, 0, 0);
    step('0, 0, 0, 0);
    chk("mid_out3", 32'(s_out), 3);
    step('0, 0, 0, 1);
    step(4'b1111, 1, 0, 0);
    chk("mid_out0", 32'(s_out), 0);
    chk("mid_rdy", 32'(s_rdy), 32'b0001);
    step('0, 0, 0, 1);
    step('0, 0, 1, 0);
    chk("mid_err", 32'(s_err), 1);

    // lock released when the locked channel withdraws
    step(4'b0100, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    chk("wd_vo", 32'(s_vo), 0);
    step(4'b0011, 1, 0, 0);
    chk("wd_rdy", 32'(s_rdy), 32'b0001);
    drain();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) burst_req_i[c] = 8'($urandom);
      step(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
